// File: rtl/asclk_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: gray-code conversion and level sizing.
package asclk_fifo_pkg;

  localparam int unsigned PTR_MAX = 32;

  // Level counters need one bit more than the address to represent "completely full".
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin[PTR_MAX-1] = gray[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) bin[i] = bin[i+1] ^ gray[i];
    return bin;
  endfunction

endpackage

// File: rtl/asclk_ptr_sync.sv
// Multi-flop synchroniser carrying a gray-coded pointer into the opposite clock domain.
module asclk_ptr_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/asclk_fifo_lvl.sv
// Dual-clock FIFO with gray-pointer crossings, per-side occupancy levels,
// almost-full/almost-empty thresholds, sticky overflow/underflow and optional FWFT.
module asclk_fifo_lvl
  import asclk_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0,
  parameter int AFULL_TH    = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_TH   = 4
) (
  input  logic                  RSTn,
  input  logic                  WCLK,
  input  logic                  RCLK,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  WE,
  input  logic                  RE,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  FULL,
  output logic                  AFULL,
  output logic                  OVF,
  output logic                  EMPTY,
  output logic                  AEMPTY,
  output logic                  UDF,
  output logic [ADDR_WIDTH:0]   WLEVEL,
  output logic [ADDR_WIDTH:0]   RLEVEL
);

  localparam int            LW         = level_width(ADDR_WIDTH);
  localparam int            DEPTH      = 2**ADDR_WIDTH;
  localparam logic [LW-1:0] DEPTH_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL  = LW'(AFULL_TH);
  localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0] wbin, wgray, wbin_next, rbin_seen, wlevel_next, rgray_sync;
  logic [LW-1:0] rbin, rgray, rbin_next, wbin_seen, rlevel_next, wgray_sync;
  logic          we_ok, re_ok, rd_en, held;

  asclk_ptr_sync #(.WIDTH(LW), .STAGES(SYNC_STAGES)) u_rptr_sync (
    .clk(WCLK), .RSTn(RSTn), .d(rgray), .q(rgray_sync)
  );

  asclk_ptr_sync #(.WIDTH(LW), .STAGES(SYNC_STAGES)) u_wptr_sync (
    .clk(RCLK), .RSTn(RSTn), .d(wgray), .q(wgray_sync)
  );

  always_comb begin
    we_ok       = WE & ~FULL;
    wbin_next   = wbin + LW'(we_ok);
    rbin_seen   = LW'(gray2bin(PTR_MAX'(rgray_sync)));
    wlevel_next = wbin_next - rbin_seen;
  end

  always_ff @(posedge WCLK or negedge RSTn) begin
    if (!RSTn) begin
      wbin   <= '0;
      wgray  <= '0;
      WLEVEL <= '0;
      FULL   <= 1'b0;
      AFULL  <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wgray  <= LW'(bin2gray(PTR_MAX'(wbin_next)));
      WLEVEL <= wlevel_next;
      FULL   <= (wlevel_next == DEPTH_LVL);
      AFULL  <= (wlevel_next >= AFULL_LVL);
      OVF    <= OVF | (WE & FULL);
    end
  end

  always_ff @(posedge WCLK) begin
    if (we_ok) mem[wbin[ADDR_WIDTH-1:0]] <= D;
  end

  // In FWFT mode rbin counts words moved into the output register, and a
  // non-empty FIFO always has that register loaded; it refills when free or popped.
  always_comb begin
    re_ok     = RE & ~EMPTY;
    wbin_seen = LW'(gray2bin(PTR_MAX'(wgray_sync)));
    rd_en     = re_ok;
    held      = 1'b0;
    if (FWFT != 0) begin
      rd_en = (wbin_seen != rbin) & (EMPTY | re_ok);
      held  = rd_en | (~EMPTY & ~re_ok);
    end
    rbin_next   = rbin + LW'(rd_en);
    rlevel_next = wbin_seen - rbin_next + LW'(held);
  end

  always_ff @(posedge RCLK or negedge RSTn) begin
    if (!RSTn) begin
      rbin   <= '0;
      rgray  <= '0;
      RLEVEL <= '0;
      EMPTY  <= 1'b1;
      AEMPTY <= 1'b1;
      UDF    <= 1'b0;
    end else begin
      rbin   <= rbin_next;
      rgray  <= LW'(bin2gray(PTR_MAX'(rbin_next)));
      RLEVEL <= rlevel_next;
      EMPTY  <= (rlevel_next == '0);
      AEMPTY <= (rlevel_next <= AEMPTY_LVL);
      UDF    <= UDF | (RE & EMPTY);
    end
  end

  always_ff @(posedge RCLK or negedge RSTn) begin
    if (!RSTn)      Q <= '0;
    else if (rd_en) Q <= mem[rbin[ADDR_WIDTH-1:0]];
  end

endmodule
